// File: rtl/acb_mem_arbiter.sv
// Round-robin arbiter with lock support that shares one ACB memory port between NUM_REQ engines.
// An in-order ID FIFO routes each memory response back to the requester that issued it.
module acb_mem_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned MAX_OUTST = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [110*NUM_REQ-1:0]        req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [64:0]                   resp_data,
   input  logic [NUM_REQ-1:0]            resp_ready,
   output logic [109:0]                  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
   output logic                          ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
   input  logic                          ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
   input  logic [64:0]                   ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
   input  logic                          ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
   output logic                          ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack,
   output logic [$clog2(MAX_OUTST):0]    outstanding
);

   localparam int unsigned REQ_W    = 110;
   localparam int unsigned LOCK_BIT = 109;
   localparam int unsigned IW       = $clog2(NUM_REQ);
   localparam int unsigned SW       = IW + 1;
   localparam int unsigned AW       = $clog2(MAX_OUTST);
   localparam int unsigned CW       = AW + 1;

   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      ISSUE        = 2'b01,
      LOCKED_IDLE  = 2'b10,
      LOCKED_ISSUE = 2'b11
   } state_t;

   state_t               state, state_next;
   logic [REQ_W-1:0]     req_arr [NUM_REQ];
   logic [REQ_W-1:0]     req_buf;
   logic [IW-1:0]        id_fifo [MAX_OUTST];
   logic [IW-1:0]        rr_ptr, lock_owner, winner, fifo_head;
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   logic [NUM_REQ-1:0]   eligible;
   logic [SW-1:0]        scan;
   logic                 buf_valid, locked, take, can_grant, grant, win_lock;
   logic                 deliver, resp_accept;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_arr[g] = req_data[REQ_W*g +: REQ_W];
   end

   assign buf_valid   = (state == ISSUE) || (state == LOCKED_ISSUE);
   assign locked      = (state == LOCKED_IDLE) || (state == LOCKED_ISSUE);
   assign take        = buf_valid && ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req;
   assign fifo_head   = id_fifo[rd_ptr];
   assign deliver     = |(resp_valid & resp_ready);
   assign resp_accept = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack &&
                        ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req;

   // Outputs decoded from registered state only; no path from resp_ready to write_ack.
   assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack   = buf_valid;
   assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data  = req_buf;
   assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = !(|resp_valid) && (count != '0);
   assign outstanding = count;

   // Winner search starting at rr_ptr; while locked only the lock owner is eligible.
   always_comb begin
      state_next = state;
      winner     = rr_ptr;
      grant      = 1'b0;
      scan       = '0;
      eligible   = req_valid;
      if (locked) eligible = req_valid & (NUM_REQ'(1) << lock_owner);
      can_grant  = (!buf_valid || take) && (count != CW'(MAX_OUTST));
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         scan = {1'b0, rr_ptr} + SW'(k);
         if (scan >= SW'(NUM_REQ)) scan = scan - SW'(NUM_REQ);
         if (!grant && eligible[IW'(scan)]) begin
            grant  = 1'b1;
            winner = IW'(scan);
         end
      end
      grant     = grant && can_grant;
      req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
      win_lock  = req_arr[winner][LOCK_BIT];
      case (state)
         IDLE, LOCKED_IDLE: begin
            if (grant) state_next = win_lock ? LOCKED_ISSUE : ISSUE;
         end
         ISSUE: begin
            if (grant)     state_next = win_lock ? LOCKED_ISSUE : ISSUE;
            else if (take) state_next = IDLE;
         end
         LOCKED_ISSUE: begin
            if (grant)     state_next = win_lock ? LOCKED_ISSUE : ISSUE;
            else if (take) state_next = LOCKED_IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Request buffer, round-robin pointer, ID FIFO pointers and response buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr     <= '0;
         lock_owner <= '0;
         req_buf    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
      end else begin
         if (grant) begin
            rr_ptr     <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);
            lock_owner <= winner;
            req_buf    <= req_arr[winner];
            wr_ptr     <= wr_ptr + AW'(1);
         end
         if (deliver) begin
            rd_ptr     <= rd_ptr + AW'(1);
            resp_valid <= '0;
         end else if (resp_accept) begin
            resp_valid <= NUM_REQ'(1) << fifo_head;
            resp_data  <= ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data;
         end
         if (grant && !deliver)      count <= count + CW'(1);
         else if (!grant && deliver) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (grant) id_fifo[wr_ptr] <= winner;
   end

endmodule
